uart_msg_printer: RTL and testbench

- Output-side companion to the UART terminal line handler. Game logic writes a complete text message byte-by-byte into an internal 256-byte buffer. The block then drains it to the UART transmit buffer (uart_tx_buf put/data/empty interface).
- During the drain it expands LF to CR LF and, optionally, appends the "$ " prompt so the terminal is ready for the next input line.
- Sits between game logic (write side) and uart_tx_buf (byte side).

---
 rtl/uart_msg_printer_pkg.sv | 26 ++
 rtl/uart_msg_printer_if.sv | 24 ++
 rtl/uart_msg_printer_bram.sv | 25 ++
 rtl/uart_msg_printer.sv | 183 ++++++++++++++++++
 tb/tb_uart_msg_printer.sv | 225 ++++++++++++++++++++++
 5 files changed

// File: rtl/uart_msg_printer_pkg.sv
// Shared types and constants for the UART message printer: FSM encoding,
// bus widths and the characters the drain path injects or recognises.
package uart_msg_printer_pkg;

  localparam int unsigned DATA_W = 8;
  localparam int unsigned WADDR_W = 8;
  localparam int unsigned LEN_W = 9;

  typedef enum logic [3:0] {
    S_FILL = 4'd0,
    S_RD   = 4'd1,
    S_LAT  = 4'd2,
    S_CHK  = 4'd3,
    S_WAIT = 4'd4,
    S_PR1  = 4'd5,
    S_PR2  = 4'd6,
    S_DONE = 4'd7
  } state_t;

  localparam logic [DATA_W-1:0] CH_LF     = 8'h0A;
  localparam logic [DATA_W-1:0] CH_CR     = 8'h0D;
  localparam logic [DATA_W-1:0] CH_NUL    = 8'h00;
  localparam logic [DATA_W-1:0] CH_PROMPT = 8'h24;
  localparam logic [DATA_W-1:0] CH_SP     = 8'h20;

endpackage

// File: rtl/uart_msg_printer_if.sv
// Write-side beat bus plus the put/data/empty link to uart_tx_buf.
interface uart_msg_printer_if;
  import uart_msg_printer_pkg::*;

  logic                w_ready;
  logic                w_valid;
  logic [DATA_W-1:0]   w_data;
  logic [WADDR_W-1:0]  w_addr;
  logic                w_last;
  logic                busy;
  logic                put;
  logic [DATA_W-1:0]   tx_data;
  logic                tx_empty;

  modport master (
    input  w_ready, busy, put, tx_data,
    output w_valid, w_data, w_addr, w_last, tx_empty
  );

  modport slave (
    output w_ready, busy, put, tx_data,
    input  w_valid, w_data, w_addr, w_last, tx_empty
  );
endinterface

// File: rtl/uart_msg_printer_bram.sv
// Single-port synchronous RAM, write-first-free, one-cycle registered read.
module uart_msg_printer_bram #(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned LEN    = 256,
  parameter int unsigned ADDR_W = 8
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [WIDTH-1:0]  din,
  output logic [WIDTH-1:0]  dout
);

  logic [WIDTH-1:0] mem [LEN];
  logic [WIDTH-1:0] dout_q;

  // No reset: contents and read register are don't-care until written.
  always_ff @(posedge clk) begin
    if (we) mem[addr] <= din;
    dout_q <= mem[addr];
  end

  assign dout = dout_q;

endmodule

// File: rtl/uart_msg_printer.sv
// Buffers one text message from game logic, then drains it byte-by-byte to
// uart_tx_buf, expanding LF to CR LF and optionally appending a "$ " prompt.
module uart_msg_printer
  import uart_msg_printer_pkg::*;
#(
  parameter int unsigned LEN       = 256,
  parameter bit          PROMPT_EN = 1'b1,
  parameter bit          LF_EXPAND = 1'b1
) (
  input  logic               clk,
  input  logic               rst_n,
  uart_msg_printer_if.slave  bus
);

  localparam int unsigned AW = (LEN > 1) ? $clog2(LEN) : 1;

  state_t             state_q, state_d;
  logic               w_ready_q, w_ready_d;
  logic               busy_q, busy_d;
  logic               put_q, put_d;
  logic [DATA_W-1:0]  tx_data_q, tx_data_d;
  logic [LEN_W-1:0]   msg_len_q, msg_len_d;
  logic [AW-1:0]      rd_idx_q, rd_idx_d;
  logic [DATA_W-1:0]  cur_q, cur_d;
  logic               lf_pend_q, lf_pend_d;
  logic               gap_q, gap_d;

  logic               w_acc;
  logic [AW-1:0]      w_idx;
  logic               tx_ok;
  logic [AW-1:0]      mem_addr;
  logic [DATA_W-1:0]  mem_dout;

  assign w_acc    = bus.w_valid && w_ready_q;
  assign w_idx    = bus.w_addr[AW-1:0];
  // gap_q masks tx_empty for the cycle after a put so uart_tx_buf can react.
  assign tx_ok    = bus.tx_empty && !gap_q;
  assign mem_addr = (state_q == S_FILL) ? w_idx : rd_idx_q;

  uart_msg_printer_bram #(
    .WIDTH  (DATA_W),
    .LEN    (LEN),
    .ADDR_W (AW)
  ) u_bram (
    .clk  (clk),
    .we   (w_acc),
    .addr (mem_addr),
    .din  (bus.w_data),
    .dout (mem_dout)
  );

  always_comb begin
    state_d   = state_q;
    w_ready_d = w_ready_q;
    busy_d    = busy_q;
    put_d     = 1'b0;
    tx_data_d = tx_data_q;
    msg_len_d = msg_len_q;
    rd_idx_d  = rd_idx_q;
    cur_d     = cur_q;
    lf_pend_d = lf_pend_q;

    unique case (state_q)
      S_FILL: begin
        if (w_acc && bus.w_last) begin
          msg_len_d = LEN_W'(w_idx) + LEN_W'(1);
          rd_idx_d  = '0;
          w_ready_d = 1'b0;
          busy_d    = 1'b1;
          state_d   = S_RD;
        end
      end
      S_RD:  state_d = S_LAT;
      S_LAT: begin
        cur_d   = mem_dout;
        state_d = S_CHK;
      end
      S_CHK: begin
        if (cur_q == CH_NUL) begin
          if (PROMPT_EN) begin
            state_d = S_PR1;
          end else begin
            state_d   = S_FILL;
            w_ready_d = 1'b1;
            busy_d    = 1'b0;
            rd_idx_d  = '0;
          end
        end else if (tx_ok) begin
          put_d   = 1'b1;
          state_d = S_WAIT;
          if (LF_EXPAND && (cur_q == CH_LF)) begin
            tx_data_d = CH_CR;
            lf_pend_d = 1'b1;
          end else begin
            tx_data_d = cur_q;
          end
        end
      end
      S_WAIT: begin
        if (tx_ok) begin
          if (lf_pend_q) begin
            put_d     = 1'b1;
            tx_data_d = CH_LF;
            lf_pend_d = 1'b0;
          end else if ((LEN_W'(rd_idx_q) + LEN_W'(1)) < msg_len_q) begin
            rd_idx_d = rd_idx_q + AW'(1);
            state_d  = S_RD;
          end else if (PROMPT_EN) begin
            state_d = S_PR1;
          end else begin
            state_d   = S_FILL;
            w_ready_d = 1'b1;
            busy_d    = 1'b0;
            rd_idx_d  = '0;
          end
        end
      end
      S_PR1: begin
        if (tx_ok) begin
          put_d     = 1'b1;
          tx_data_d = CH_PROMPT;
          state_d   = S_PR2;
        end
      end
      S_PR2: begin
        if (tx_ok) begin
          put_d     = 1'b1;
          tx_data_d = CH_SP;
          state_d   = S_DONE;
        end
      end
      S_DONE: begin
        if (tx_ok) begin
          state_d   = S_FILL;
          w_ready_d = 1'b1;
          busy_d    = 1'b0;
          rd_idx_d  = '0;
        end
      end
      default: begin
        state_d   = S_FILL;
        w_ready_d = 1'b1;
        busy_d    = 1'b0;
        rd_idx_d  = '0;
        lf_pend_d = 1'b0;
      end
    endcase

    gap_d = put_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_FILL;
      w_ready_q <= 1'b1;
      busy_q    <= 1'b0;
      put_q     <= 1'b0;
      tx_data_q <= '0;
      msg_len_q <= '0;
      rd_idx_q  <= '0;
      cur_q     <= '0;
      lf_pend_q <= 1'b0;
      gap_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      w_ready_q <= w_ready_d;
      busy_q    <= busy_d;
      put_q     <= put_d;
      tx_data_q <= tx_data_d;
      msg_len_q <= msg_len_d;
      rd_idx_q  <= rd_idx_d;
      cur_q     <= cur_d;
      lf_pend_q <= lf_pend_d;
      gap_q     <= gap_d;
    end
  end

  assign bus.w_ready = w_ready_q;
  assign bus.busy    = busy_q;
  assign bus.put     = put_q;
  assign bus.tx_data = tx_data_q;

endmodule

// File: tb/tb_uart_msg_printer.sv
// Directed bench: two printers (LF expansion on/off) fed the same messages,
// each draining into a 10-cycle-per-byte uart_tx_buf model.
module tb_uart_msg_printer;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic       w_valid = 1'b0;
  logic [7:0] w_data  = 8'h00;
  logic [7:0] w_addr  = 8'h00;
  logic       w_last  = 1'b0;
  logic       stall   = 1'b0;

  int checks = 0;
  int errors = 0;

  uart_msg_printer_if ifa ();
  uart_msg_printer_if ifb ();

  assign ifa.w_valid = w_valid;
  assign ifa.w_data  = w_data;
  assign ifa.w_addr  = w_addr;
  assign ifa.w_last  = w_last;
  assign ifb.w_valid = w_valid;
  assign ifb.w_data  = w_data;
  assign ifb.w_addr  = w_addr;
  assign ifb.w_last  = w_last;

  uart_msg_printer #(.LEN(256), .PROMPT_EN(1'b1), .LF_EXPAND(1'b1)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifa.slave)
  );

  uart_msg_printer #(.LEN(256), .PROMPT_EN(1'b1), .LF_EXPAND(1'b0)) dut_nx (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifb.slave)
  );

  // uart_tx_buf model: busy for 10 cycles after it sees a put
  int cnt_a = 0;
  int cnt_b = 0;
  always @(posedge clk) begin
    if (ifa.put) cnt_a <= 10; else if (cnt_a > 0) cnt_a <= cnt_a - 1;
    if (ifb.put) cnt_b <= 10; else if (cnt_b > 0) cnt_b <= cnt_b - 1;
  end
  assign ifa.tx_empty = (cnt_a == 0) && !stall;
  assign ifb.tx_empty = (cnt_b == 0) && !stall;

  logic [7:0] qa[$];
  logic [7:0] qb[$];
  int  stall_puts = 0;
  int  viol = 0;
  logic prev_empty_a = 1'b1;
  logic prev_empty_b = 1'b1;

  always @(negedge clk) begin
    if (ifa.put) begin
      qa.push_back(ifa.tx_data);
      if (!prev_empty_a) viol++;
    end
    if (ifb.put) begin
      qb.push_back(ifb.tx_data);
      if (!prev_empty_b) viol++;
    end
    if (stall && (ifa.put || ifb.put)) stall_puts++;
    prev_empty_a = ifa.tx_empty;
    prev_empty_b = ifb.tx_empty;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic chk_q(input string tag, input logic [7:0] got[$], input logic [7:0] exp[$]);
    int n;
    chk({tag, " count"}, 32'(got.size()), 32'(exp.size()));
    n = (got.size() < exp.size()) ? got.size() : exp.size();
    for (int i = 0; i < n; i++) chk($sformatf("%s byte%0d", tag, i), 32'(got[i]), 32'(exp[i]));
  endtask

  task automatic wbeat(input logic [7:0] a, input logic [7:0] d, input logic l);
    w_valid = 1'b1;
    w_addr  = a;
    w_data  = d;
    w_last  = l;
    @(negedge clk);
    w_valid = 1'b0;
    w_last  = 1'b0;
  endtask

  task automatic send(input logic [7:0] msg[$]);
    for (int i = 0; i < msg.size(); i++) wbeat(8'(i), msg[i], i == msg.size() - 1);
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while ((ifa.busy || ifb.busy) && n < 20000) begin
      @(negedge clk);
      n++;
    end
    chk({tag, " drain timeout"}, 32'(n < 20000), 32'd1);
  endtask

  task automatic wait_puts(input int k, input string tag);
    int n = 0;
    while (qa.size() < k && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk({tag, " put timeout"}, 32'(n < 2000), 32'd1);
  endtask

  logic [7:0] msg[$];
  logic [7:0] ea[$];
  logic [7:0] eb[$];

  initial begin
    #12;
    chk("rst w_ready", 32'(ifa.w_ready), 32'd1);
    chk("rst busy", 32'(ifa.busy), 32'd0);
    chk("rst put", 32'(ifa.put), 32'd0);
    chk("rst tx_data", 32'(ifa.tx_data), 32'h00);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // "hi"
    qa.delete(); qb.delete();
    send('{8'h68, 8'h69});
    chk("hi busy", 32'(ifa.busy), 32'd1);
    chk("hi w_ready low", 32'(ifa.w_ready), 32'd0);
    wait_idle("hi");
    ea = '{8'h68, 8'h69, 8'h24, 8'h20};
    chk_q("hi", qa, ea);
    chk("hi w_ready back", 32'(ifa.w_ready), 32'd1);

    // "a\nb": expansion on vs off
    qa.delete(); qb.delete();
    send('{8'h61, 8'h0A, 8'h62});
    wait_idle("lf");
    ea = '{8'h61, 8'h0D, 8'h0A, 8'h62, 8'h24, 8'h20};
    eb = '{8'h61, 8'h0A, 8'h62, 8'h24, 8'h20};
    chk_q("lf exp", qa, ea);
    chk_q("lf raw", qb, eb);

    // NUL terminates early
    qa.delete(); qb.delete();
    send('{8'h6F, 8'h6B, 8'h00, 8'h78});
    wait_idle("nul");
    ea = '{8'h6F, 8'h6B, 8'h24, 8'h20};
    chk_q("nul", qa, ea);

    // full 256-byte message
    qa.delete(); qb.delete();
    msg.delete(); ea.delete();
    for (int i = 0; i < 256; i++) msg.push_back(8'h30 + 8'(i % 64));
    ea = msg;
    ea.push_back(8'h24);
    ea.push_back(8'h20);
    send(msg);
    wait_idle("full");
    chk_q("full", qa, ea);

    // 500-cycle stall with ignored write pulses
    qa.delete(); qb.delete();
    send('{8'h73, 8'h74, 8'h61, 8'h6C, 8'h6C});
    wait_puts(2, "stall");
    stall = 1'b1;
    for (int c = 0; c < 500; c++) begin
      if (c % 50 == 10) begin
        chk("stall w_ready", 32'(ifa.w_ready), 32'd0);
        wbeat(8'h00, 8'h51, 1'b1);
      end else begin
        @(negedge clk);
      end
    end
    stall = 1'b0;
    chk("stall busy", 32'(ifa.busy), 32'd1);
    wait_idle("stall");
    chk("stall puts", 32'(stall_puts), 32'd0);
    ea = '{8'h73, 8'h74, 8'h61, 8'h6C, 8'h6C, 8'h24, 8'h20};
    chk_q("stall", qa, ea);

    // only addr 1 written: addr 0 keeps "s", not the rejected 0x51
    qa.delete(); qb.delete();
    wbeat(8'h01, 8'h6B, 1'b1);
    wait_idle("stale");
    ea = '{8'h73, 8'h6B, 8'h24, 8'h20};
    chk_q("stale", qa, ea);

    // async reset between two puts
    qa.delete(); qb.delete();
    send('{8'h72, 8'h65, 8'h73, 8'h65, 8'h74});
    wait_puts(2, "rst");
    repeat (4) @(negedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("mid rst put", 32'(ifa.put), 32'd0);
    chk("mid rst busy", 32'(ifa.busy), 32'd0);
    chk("mid rst w_ready", 32'(ifa.w_ready), 32'd1);
    @(negedge clk);
    @(negedge clk);
    qa.delete(); qb.delete();
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("post rst no put", 32'(qa.size()), 32'd0);
    send('{8'h7A});
    wait_idle("z");
    ea = '{8'h7A, 8'h24, 8'h20};
    chk_q("z", qa, ea);

    chk("put only when empty", 32'(viol), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
